// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Sequences one MULT or DIV through the shared multiply/divide units. It pulses the
// selected unit's start, waits for its completion flag (bounded by TIMEOUT cycles),
// then either writes HI/LO and signals op_done, or raises a one-cycle exception.
// All strobes are Moore outputs decoded from the current state.
module muldiv_sequencer #(
    parameter int TIMEOUT = 64,   // max cycles in a WAIT state before ERR; >= 2
    parameter int CNT_W   = 7     // wait counter width; 2**CNT_W > TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       op_start,
    input  logic       op_div,
    input  logic       mult_done,
    input  logic       div_done,
    input  logic       div_zero,
    output logic       mult_start,
    output logic       div_start,
    output logic       hilo_sel,
    output logic       hi_write,
    output logic       lo_write,
    output logic       busy,
    output logic       op_done,
    output logic       exc_divzero,
    output logic       exc_timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MSTART = 3'd1,
        S_MWAIT  = 3'd2,
        S_DSTART = 3'd3,
        S_DWAIT  = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hilo_sel_q, hilo_sel_d;
    // Remembers which exception ERR must report: 1 = divide-by-zero, 0 = timeout.
    logic             exc_zero_q, exc_zero_d;

    // State, wait counter, HI/LO select and exception type registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            hilo_sel_q <= 1'b0;
            exc_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge
            // values, independent of statement order.
            state_q    <= state_d;
            count_q    <= count_d;
            hilo_sel_q <= hilo_sel_d;
            exc_zero_q <= exc_zero_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        hilo_sel_d  = hilo_sel_q;
        exc_zero_d  = exc_zero_q;
        mult_start  = 1'b0;
        div_start   = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
        op_done     = 1'b0;
        exc_divzero = 1'b0;
        exc_timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                // op_start is only honoured here; requests while busy are dropped.
                if (op_start) begin
                    hilo_sel_d = op_div;
                    state_d    = op_div ? S_DSTART : S_MSTART;
                end
            end
            S_MSTART: begin
                mult_start = 1'b1;
                count_d    = '0;
                state_d    = S_MWAIT;
            end
            S_DSTART: begin
                div_start = 1'b1;
                count_d   = '0;
                state_d   = S_DWAIT;
            end
            S_MWAIT: begin
                // Completion wins over a timeout in the same cycle.
                if (mult_done) begin
                    state_d = S_WRITE;
                end else if (count_q == LAST_COUNT) begin
                    exc_zero_d = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_DWAIT: begin
                // Divide-by-zero wins over completion, which wins over timeout.
                if (div_zero) begin
                    exc_zero_d = 1'b1;
                    state_d    = S_ERR;
                end else if (div_done) begin
                    state_d = S_WRITE;
                end else if (count_q == LAST_COUNT) begin
                    exc_zero_d = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                op_done = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                exc_divzero = exc_zero_q;
                exc_timeout = ~exc_zero_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hilo_sel = hilo_sel_q;
    assign busy     = (state_q != S_IDLE);
    assign state    = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Table-driven bench: each record describes one operation (type, when the completion /
// zero / stray flags are driven) and the hand-computed cycle of every strobe. Cycle 0 is
// the cycle op_start is high. Extra hand-written sequences cover ignored requests and
// asynchronous reset.
module tb_muldiv_sequencer;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;
    localparam int MAXC    = TIMEOUT + 10;
    localparam int NVEC    = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       op_start, op_div, mult_done, div_done, div_zero;
    logic       mult_start, div_start, hilo_sel, hi_write, lo_write;
    logic       busy, op_done, exc_divzero, exc_timeout;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_start    (op_start),
        .op_div      (op_div),
        .mult_done   (mult_done),
        .div_done    (div_done),
        .div_zero    (div_zero),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .hilo_sel    (hilo_sel),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .busy        (busy),
        .op_done     (op_done),
        .exc_divzero (exc_divzero),
        .exc_timeout (exc_timeout),
        .state       (state)
    );

    always #5 clock = ~clock;

    // One operation: stimulus timing and expected strobe cycles (-1 = never).
    typedef struct {
        int op_div;
        int done_cyc;   // cycle the matching done flag is high
        int zero_cyc;   // cycle div_zero is high
        int noise_cyc;  // cycle the non-matching unit's flags are high
        int exp_write;
        int exp_done;
        int exp_exz;
        int exp_ext;
        int exp_idle;   // first cycle >= 1 with busy = 0
        int exp_hilo;
    } vec_t;

    // Observed behaviour of one operation.
    typedef struct {
        int mstart_cyc, mstart_cnt, dstart_cyc, dstart_cnt;
        int write_cyc, write_cnt, lo_diff;
        int done_cyc, done_cnt;
        int exz_cyc, exz_cnt, ext_cyc, ext_cnt;
        int idle_cyc, hilo_at_idle, state_at_idle, state_c2;
    } res_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        op_start  = 1'b0;
        mult_done = 1'b0;
        div_done  = 1'b0;
        div_zero  = 1'b0;
    endtask

    // Runs one operation starting at posedge+1; returns aligned to posedge+1.
    // restart_a/restart_b give cycles where a further op_start is driven.
    task automatic run_op(input int div, input int done_c, input int zero_c,
                          input int noise_c, input int restart_a, input int restart_b,
                          output res_t r);
        r = '{default: -1};
        r.mstart_cnt = 0; r.dstart_cnt = 0; r.write_cnt = 0; r.lo_diff = 0;
        r.done_cnt = 0; r.exz_cnt = 0; r.ext_cnt = 0;
        op_div = div[0];
        for (int c = 0; c < MAXC; c++) begin
            op_start  = (c == 0) || (c == restart_a) || (c == restart_b);
            mult_done = (div == 0 && c == done_c) || (div != 0 && c == noise_c);
            div_done  = (div != 0 && c == done_c) || (div == 0 && c == noise_c);
            div_zero  = (c == zero_c) || (div == 0 && c == noise_c);
            @(negedge clock);
            if (mult_start) begin if (r.mstart_cyc < 0) r.mstart_cyc = c; r.mstart_cnt++; end
            if (div_start)  begin if (r.dstart_cyc < 0) r.dstart_cyc = c; r.dstart_cnt++; end
            if (hi_write)   begin if (r.write_cyc < 0)  r.write_cyc = c;  r.write_cnt++;  end
            if (hi_write != lo_write) r.lo_diff++;
            if (op_done)     begin if (r.done_cyc < 0) r.done_cyc = c; r.done_cnt++; end
            if (exc_divzero) begin if (r.exz_cyc < 0)  r.exz_cyc = c;  r.exz_cnt++;  end
            if (exc_timeout) begin if (r.ext_cyc < 0)  r.ext_cyc = c;  r.ext_cnt++;  end
            if (c == 2) r.state_c2 = int'(state);
            if (c >= 1 && !busy) begin
                r.idle_cyc      = c;
                r.hilo_at_idle  = int'(hilo_sel);
                r.state_at_idle = int'(state);
                break;
            end
            @(posedge clock); #1;
        end
        clear_inputs();
        if (r.idle_cyc < 0) begin
            $display("FAIL op_bound: busy never dropped within %0d cycles", MAXC);
        end else begin
            @(posedge clock); #1;
        end
    endtask

    task automatic apply_vec(input int i);
        res_t r;
        vec_t v;
        string p;
        v = vecs[i];
        p = $sformatf("vec%0d", i);
        run_op(v.op_div, v.done_cyc, v.zero_cyc, v.noise_cyc, -1, -1, r);
        if (v.op_div != 0) begin
            check({p, ".div_start_cyc"}, r.dstart_cyc, 1);
            check({p, ".div_start_cnt"}, r.dstart_cnt, 1);
            check({p, ".mult_start_cnt"}, r.mstart_cnt, 0);
            check({p, ".state_c2"}, r.state_c2, 4);
        end else begin
            check({p, ".mult_start_cyc"}, r.mstart_cyc, 1);
            check({p, ".mult_start_cnt"}, r.mstart_cnt, 1);
            check({p, ".div_start_cnt"}, r.dstart_cnt, 0);
            check({p, ".state_c2"}, r.state_c2, 2);
        end
        check({p, ".write_cyc"}, r.write_cyc, v.exp_write);
        check({p, ".write_cnt"}, r.write_cnt, (v.exp_write >= 0) ? 1 : 0);
        check({p, ".hi_lo_differ"}, r.lo_diff, 0);
        check({p, ".op_done_cyc"}, r.done_cyc, v.exp_done);
        check({p, ".op_done_cnt"}, r.done_cnt, (v.exp_done >= 0) ? 1 : 0);
        check({p, ".exc_divzero_cyc"}, r.exz_cyc, v.exp_exz);
        check({p, ".exc_divzero_cnt"}, r.exz_cnt, (v.exp_exz >= 0) ? 1 : 0);
        check({p, ".exc_timeout_cyc"}, r.ext_cyc, v.exp_ext);
        check({p, ".exc_timeout_cnt"}, r.ext_cnt, (v.exp_ext >= 0) ? 1 : 0);
        check({p, ".idle_cyc"}, r.idle_cyc, v.exp_idle);
        check({p, ".state_idle"}, r.state_at_idle, 0);
        check({p, ".hilo_sel"}, r.hilo_at_idle, v.exp_hilo);
    endtask

    // All outputs packed for reset-state comparisons.
    function automatic int out_bits();
        return int'({mult_start, div_start, hilo_sel, hi_write, lo_write, busy,
                     op_done, exc_divzero, exc_timeout, state});
    endfunction

    initial begin
        res_t r;
        int   n;

        //        div done zero noise  write done exz ext idle hilo
        vecs[0] = '{0,   5,  -1,  -1,    6,    7,  -1, -1,   8,  0};  // basic MULT
        vecs[1] = '{1,  -1,   3,  -1,   -1,   -1,   4, -1,   5,  1};  // divide by zero
        vecs[2] = '{1,  -1,  -1,  -1,   -1,   -1,  -1, 66,  67,  1};  // DIV timeout
        vecs[3] = '{1,   2,   2,  -1,   -1,   -1,   3, -1,   4,  1};  // zero beats done
        vecs[4] = '{0,  65,  -1,  -1,   66,   67,  -1, -1,  68,  0};  // done beats timeout
        vecs[5] = '{1,   2,  -1,  -1,    3,    4,  -1, -1,   5,  1};  // minimum latency
        vecs[6] = '{0,  -1,  -1,  -1,   -1,   -1,  -1, 66,  67,  0};  // MULT timeout
        vecs[7] = '{0,   4,  -1,   3,    5,    6,  -1, -1,   7,  0};  // div flags ignored
        vecs[8] = '{1,  10,  -1,   5,   11,   12,  -1, -1,  13,  1};  // mult flag ignored
        vecs[9] = '{1,   4,   1,  -1,    5,    6,  -1, -1,   7,  1};  // zero in DSTART ignored

        op_div = 1'b0;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", out_bits(), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < NVEC; i++) apply_vec(i);

        // Requests during MWAIT and DONE are dropped, not queued.
        run_op(0, 5, -1, -1, 3, 7, r);
        check("restart_mult_start_cnt", r.mstart_cnt, 1);
        check("restart_op_done_cnt", r.done_cnt, 1);
        check("restart_op_done_cyc", r.done_cyc, 7);
        check("restart_idle_cyc", r.idle_cyc, 8);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (busy) n++;
            @(posedge clock); #1;
        end
        check("restart_no_queue_busy", n, 0);

        // Requests during DWAIT and ERR are dropped too.
        run_op(1, -1, 3, -1, 2, 4, r);
        check("err_restart_div_start_cnt", r.dstart_cnt, 1);
        check("err_restart_exc_divzero_cyc", r.exz_cyc, 4);
        check("err_restart_idle_cyc", r.idle_cyc, 5);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (busy) n++;
            @(posedge clock); #1;
        end
        check("err_restart_no_queue_busy", n, 0);

        // Asynchronous reset in the middle of DWAIT.
        op_div   = 1'b1;
        op_start = 1'b1;
        @(posedge clock); #1;
        op_start = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        check("pre_reset_state_dwait", int'(state), 4);
        check("pre_reset_hilo_sel", int'(hilo_sel), 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", out_bits(), 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        apply_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
